// File: rtl/mips_exec_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_exec_ctrl_if
// Command port between the debug/host side and the execution controller.
//   cmd_valid  host -> ctrl  command present
//   cmd        host -> ctrl  opcode (0 CLEAR, 1 RUN, 2 STEP, 3 HALT,
//                            4 SET_BP, 5 CLR_BP, 6-7 reserved)
//   cmd_arg    host -> ctrl  STEP: cycle count in [15:0]; SET_BP: breakpoint PC
//   cmd_ready  ctrl -> host  command taken on an edge with cmd_valid & cmd_ready
// Modports: master (host side), slave (controller side).
// -----------------------------------------------------------------------------
interface mips_exec_ctrl_if #(
    parameter int unsigned SIZE = 32
) ();
    logic            cmd_valid;
    logic [2:0]      cmd;
    logic [SIZE-1:0] cmd_arg;
    logic            cmd_ready;

    modport master (output cmd_valid, output cmd, output cmd_arg, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd, input  cmd_arg, output cmd_ready);
endinterface

// File: rtl/mips_exec_ctrl.sv
// -----------------------------------------------------------------------------
// mips_exec_ctrl
// Execution controller for the mips core. Owns the core's stall input and
// sequences it from a host command port: run, counted step, halt, breakpoint
// set/clear and clear. A fetched halt instruction drains the pipeline for
// PIPE_DEPTH cycles and then parks in END; a breakpoint hit stops at once.
// Counts unstalled cycles (saturating) for the host.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   cmd_if         command port (slave modport of mips_exec_ctrl_if)
//   i_pc           core fetch PC (breakpoint compare)
//   i_halt_instr   core fetched the halt opcode this cycle
//   o_stall        core stall, registered
//   o_state        FSM state: HALTED=0 RUN=1 STEP=2 DRAIN=3 END=4
//   o_halt_reason  0 none, 1 HALT cmd / step done, 2 breakpoint, 3 halt instr
//   o_done         one-cycle pulse on every entry to HALTED or END
//   o_cycle_count  unstalled cycles, saturating at 0xFFFF_FFFF
//
// Build option: define MIPS_EXEC_BREAKPOINT_EN to build the breakpoint
// register and PC comparator; otherwise SET_BP/CLR_BP are accepted no-ops.
// -----------------------------------------------------------------------------
module mips_exec_ctrl #(
    parameter int unsigned SIZE       = 32,
    parameter int unsigned PIPE_DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    mips_exec_ctrl_if.slave  cmd_if,
    input  logic [SIZE-1:0]  i_pc,
    input  logic             i_halt_instr,
    output logic             o_stall,
    output logic [2:0]       o_state,
    output logic [1:0]       o_halt_reason,
    output logic             o_done,
    output logic [31:0]      o_cycle_count
);

    typedef enum logic [2:0] {
        ST_HALTED = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_END    = 3'd4
    } state_t;

    localparam logic [2:0] CMD_CLEAR  = 3'd0;
    localparam logic [2:0] CMD_RUN    = 3'd1;
    localparam logic [2:0] CMD_STEP   = 3'd2;
    localparam logic [2:0] CMD_HALT   = 3'd3;
    localparam logic [2:0] CMD_SET_BP = 3'd4;
    localparam logic [2:0] CMD_CLR_BP = 3'd5;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    state_t      state_r, state_next_s;
    logic [15:0] cnt_r, cnt_next_s;
    logic [1:0]  reason_r, reason_next_s;
    logic [31:0] cycles_r;
    logic        stall_r, ready_r, done_r;
    logic        stall_next_s, ready_next_s, done_next_s;
    logic        accept_s, clear_s, bp_set_s, bp_clr_s, bp_hit_s;
    logic [15:0] step_load_s;

    assign accept_s    = cmd_if.cmd_valid & ready_r;
    // A step count of zero still runs one cycle.
    assign step_load_s = (cmd_if.cmd_arg[15:0] == 16'd0) ? 16'd1 : cmd_if.cmd_arg[15:0];

`ifdef MIPS_EXEC_BREAKPOINT_EN
    logic [SIZE-1:0] bp_addr_r;
    logic            bp_valid_r;

    // Breakpoint register: loaded by SET_BP, invalidated by CLR_BP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bp_addr_r  <= {SIZE{1'b0}};
            bp_valid_r <= 1'b0;
        end else if (bp_set_s) begin
            bp_addr_r  <= cmd_if.cmd_arg;
            bp_valid_r <= 1'b1;
        end else if (bp_clr_s) begin
            bp_valid_r <= 1'b0;
        end
    end

    assign bp_hit_s = bp_valid_r & (i_pc == bp_addr_r);
`else
    logic unused_bp_s;
    assign unused_bp_s = ^{i_pc, cmd_if.cmd_arg[SIZE-1:16], bp_set_s, bp_clr_s};
    assign bp_hit_s    = 1'b0;
`endif

    // State and per-state bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_HALTED;
            cnt_r    <= 16'd0;
            reason_r <= 2'd0;
            stall_r  <= 1'b1;
            ready_r  <= 1'b0;
            done_r   <= 1'b0;
            cycles_r <= 32'd0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            reason_r <= reason_next_s;
            stall_r  <= stall_next_s;
            ready_r  <= ready_next_s;
            done_r   <= done_next_s;
            // CLEAR is only acted on in stalled states, so it never races an increment.
            if (clear_s) begin
                cycles_r <= 32'd0;
            end else if (!stall_r) begin
                cycles_r <= sat_inc(cycles_r);
            end
        end
    end

    // Next-state decision; RUN priority is HALT cmd > halt instr > breakpoint.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        reason_next_s = reason_r;
        clear_s       = 1'b0;
        bp_set_s      = 1'b0;
        bp_clr_s      = 1'b0;
        case (state_r)
            ST_HALTED: begin
                if (accept_s) begin
                    case (cmd_if.cmd)
                        CMD_RUN:    state_next_s = ST_RUN;
                        CMD_STEP: begin
                            state_next_s = ST_STEP;
                            cnt_next_s   = step_load_s;
                        end
                        CMD_CLEAR: begin
                            clear_s       = 1'b1;
                            reason_next_s = 2'd0;
                        end
                        CMD_SET_BP: bp_set_s = 1'b1;
                        CMD_CLR_BP: bp_clr_s = 1'b1;
                        default:    state_next_s = ST_HALTED;
                    endcase
                end else begin
                    state_next_s = ST_HALTED;
                end
            end
            ST_RUN: begin
                if (accept_s && (cmd_if.cmd == CMD_HALT)) begin
                    state_next_s  = ST_HALTED;
                    reason_next_s = 2'd1;
                end else if (i_halt_instr) begin
                    state_next_s = ST_DRAIN;
                    cnt_next_s   = 16'(PIPE_DEPTH);
                end else if (bp_hit_s) begin
                    state_next_s  = ST_HALTED;
                    reason_next_s = 2'd2;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STEP: begin
                if (i_halt_instr) begin
                    state_next_s = ST_DRAIN;
                    cnt_next_s   = 16'(PIPE_DEPTH);
                end else if (bp_hit_s) begin
                    state_next_s  = ST_HALTED;
                    reason_next_s = 2'd2;
                end else if (cnt_r == 16'd1) begin
                    state_next_s  = ST_HALTED;
                    reason_next_s = 2'd1;
                end else begin
                    cnt_next_s = cnt_r - 16'd1;
                end
            end
            ST_DRAIN: begin
                if (cnt_r == 16'd1) begin
                    state_next_s  = ST_END;
                    reason_next_s = 2'd3;
                end else begin
                    cnt_next_s = cnt_r - 16'd1;
                end
            end
            ST_END: begin
                if (accept_s && (cmd_if.cmd == CMD_CLEAR)) begin
                    state_next_s  = ST_HALTED;
                    clear_s       = 1'b1;
                    reason_next_s = 2'd0;
                end else begin
                    state_next_s = ST_END;
                end
            end
            default: begin
                state_next_s  = ST_HALTED;
                reason_next_s = 2'd0;
            end
        endcase
    end

    // Output decode from the next state so stall/ready/done are registered.
    always_comb begin
        stall_next_s = 1'b1;
        ready_next_s = 1'b1;
        case (state_next_s)
            ST_HALTED: begin stall_next_s = 1'b1; ready_next_s = 1'b1; end
            ST_RUN:    begin stall_next_s = 1'b0; ready_next_s = 1'b1; end
            ST_STEP:   begin stall_next_s = 1'b0; ready_next_s = 1'b0; end
            ST_DRAIN:  begin stall_next_s = 1'b0; ready_next_s = 1'b0; end
            ST_END:    begin stall_next_s = 1'b1; ready_next_s = 1'b1; end
            default:   begin stall_next_s = 1'b1; ready_next_s = 1'b1; end
        endcase
        done_next_s = (state_next_s != state_r) &&
                      ((state_next_s == ST_HALTED) || (state_next_s == ST_END));
    end

    assign cmd_if.cmd_ready = ready_r;
    assign o_stall          = stall_r;
    assign o_state          = state_r;
    assign o_halt_reason    = reason_r;
    assign o_done           = done_r;
    assign o_cycle_count    = cycles_r;

endmodule
